led_strip_ctrl: RTL and testbench

Sequencer for a WS2812-style serial LED strip. Fetches NUM_LEDS 24-bit pixels from a frame buffer and drives load/shift of the external 24-bit MSB-first LED shift register. Generates single-wire NRZ timing on dout from the register MSB, then holds the line low for the latch/reset period. Sits between the frame-buffer RAM and the strip pin.

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_bit_timer.sv | 64 ++++++
 rtl/led_strip_ctrl.sv | 116 +++++++++++
 tb/tb_led_strip_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared state encoding and default 50 MHz timing for the WS2812 strip sequencer.
// The optional LED_AUTO_REFRESH_EN build reuses these definitions unchanged.
package led_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_BIT,
    S_NEXT,
    S_LATCH,
    S_DONE
  } led_state_e;

  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_WIDTH    = 24;
  localparam int DEF_T0H      = 20;
  localparam int DEF_T1H      = 40;
  localparam int DEF_T_BIT    = 62;
  localparam int DEF_T_RST    = 3000;

  // Bits needed for a counter that must reach max(a, b) - 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Cycle counter shared by the bit period and the latch period, plus the
// registered NRZ line: dout in each cycle is decided one cycle ahead.
module led_bit_timer
  import led_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int T_BIT = DEF_T_BIT,
  parameter int T_RST = DEF_T_RST
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run_bit,
  input  logic i_run_latch,
  input  logic i_bit_nxt,
  input  logic i_bit_in,
  output logic o_end_bit,
  output logic o_end_latch,
  output logic o_dout
);

  localparam int CNT_W = cnt_width(T_BIT, T_RST);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_bit;
  logic             w_bit;
  logic             w_high_nxt;
  logic             r_dout;

  always_comb begin
    o_end_bit   = i_run_bit && (r_cnt == BIT_LAST);
    o_end_latch = i_run_latch && (r_cnt == RST_LAST);
    w_cnt_nxt   = '0;
    if ((i_run_bit && !o_end_bit) || (i_run_latch && !o_end_latch)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    // At cnt=0 the shift-register MSB is live; afterwards use the held copy.
    // When the next count is 0 the line is high regardless of the bit value.
    w_bit      = (r_cnt == '0) ? i_bit_in : r_bit;
    w_high_nxt = i_bit_nxt && (w_cnt_nxt < (w_bit ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_bit  <= 1'b0;
      r_dout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (i_run_bit && (r_cnt == '0)) begin
        r_bit <= i_bit_in;
      end
      r_dout <= w_high_nxt;
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/led_strip_ctrl.sv
// WS2812 frame sequencer: fetch pixel, load the external shift register, send
// WIDTH NRZ bits MSB first, repeat per pixel, then hold the latch low.
// Optional macro LED_AUTO_REFRESH_EN adds auto_en for back-to-back frames.
module led_strip_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T_RST    = DEF_T_RST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef LED_AUTO_REFRESH_EN
  input  logic              auto_en,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              load,
  output logic              shift,
  input  logic              bit_in,
  output logic              dout,
  output led_state_e        o_dbg_state
);

  localparam int BIT_IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0]    LAST_LED = ADDR_W'(NUM_LEDS - 1);

  led_state_e           r_state;
  led_state_e           w_state_nxt;
  logic [ADDR_W-1:0]    r_led_idx;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 w_end_bit;
  logic                 w_end_latch;
  logic                 w_last_bit;
  logic                 w_auto;

`ifdef LED_AUTO_REFRESH_EN
  assign w_auto = auto_en;
`else
  assign w_auto = 1'b0;
`endif

  // Handshake-free interface: rd_en/load/shift/done are single-cycle strobes
  // decoded from the state register; the partner reacts in that same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_last_bit  = (r_bit_idx == LAST_BIT);
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_BIT;
      S_BIT:   if (w_end_bit && w_last_bit) w_state_nxt = S_NEXT;
      S_NEXT:  w_state_nxt = (r_led_idx == LAST_LED) ? S_LATCH : S_FETCH;
      S_LATCH: if (w_end_latch) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_auto ? S_FETCH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (r_state == S_FETCH);
    load  = (r_state == S_LOAD);
    shift = (r_state == S_BIT) && w_end_bit && !w_last_bit;
    done  = (r_state == S_DONE);
    busy  = (r_state != S_IDLE) && !((r_state == S_DONE) && !w_auto);
    addr  = r_led_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_led_idx <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_led_idx <= '0;
      end else if ((r_state == S_NEXT) && (r_led_idx != LAST_LED)) begin
        r_led_idx <= r_led_idx + ADDR_W'(1);
      end
      if (r_state == S_LOAD) begin
        r_bit_idx <= '0;
      end else if (shift) begin
        r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      end
    end
  end

  led_bit_timer #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT),
    .T_RST (T_RST)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_run_bit   (r_state == S_BIT),
    .i_run_latch (r_state == S_LATCH),
    .i_bit_nxt   (w_state_nxt == S_BIT),
    .i_bit_in    (bit_in),
    .o_end_bit   (w_end_bit),
    .o_end_latch (w_end_latch),
    .o_dout      (dout)
  );

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_strip_ctrl.sv
// Bench for led_strip_ctrl with small timing: frame model by cycle offset,
// per-cycle compare, and literal pulse-width checks on directed frames.
module tb_led_strip_ctrl;
  import led_pkg::*;

  localparam int N     = 2;
  localparam int AW    = 3;
  localparam int W     = 24;
  localparam int T0    = 2;
  localparam int T1    = 4;
  localparam int TB    = 6;
  localparam int TR    = 10;
  localparam int P     = 3 + W * TB;
  localparam int FRAME = N * P + TR + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bit_in;
  logic          busy, done, rd_en, load, shift, dout;
  logic [AW-1:0] addr;
  led_state_e    dbg_state;
  logic          au_w;
`ifdef LED_AUTO_REFRESH_EN
  logic          auto_en = 1'b0;
  assign au_w = auto_en;
`else
  assign au_w = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_strip_ctrl #(
    .NUM_LEDS (N), .ADDR_W (AW), .WIDTH (W),
    .T0H (T0), .T1H (T1), .T_BIT (TB), .T_RST (TR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef LED_AUTO_REFRESH_EN
    .auto_en     (auto_en),
`endif
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .addr        (addr),
    .load        (load),
    .shift       (shift),
    .bit_in      (bit_in),
    .dout        (dout),
    .o_dbg_state (dbg_state)
  );

  // Frame-buffer RAM (1-cycle latency) and external MSB-first shift register.
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] ram_q = '0;
  logic [W-1:0] sreg = '0;
  always @(posedge clk) if (rd_en) ram_q <= mem[addr];
  always @(negedge clk) begin
    if (load) sreg <= ram_q;
    else if (shift) sreg <= {sreg[W-2:0], 1'b0};
  end
  assign bit_in = sreg[W-1];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a frame is a fixed sequence of cycles counted from the first FETCH.
  typedef struct packed {
    logic          busy, done, rd_en, load, shift, dout, chk_addr;
    logic [AW-1:0] addr;
  } exp_t;

  function automatic exp_t model_at(input bit act, input int t, input logic au);
    exp_t e;
    int p, r, b, c;
    logic v;
    e = '0;
    if (!act) return e;
    if (t < N * P) begin
      e.busy = 1'b1;
      p = t / P;
      r = t % P;
      if (r == 0) begin
        e.rd_en = 1'b1; e.addr = AW'(p); e.chk_addr = 1'b1;
      end else if (r == 1) begin
        e.load = 1'b1;
      end else if (r < P - 1) begin
        b = (r - 2) / TB;
        c = (r - 2) % TB;
        v = mem[p][W-1-b];
        e.dout  = (c < (v ? T1 : T0));
        e.shift = (c == TB - 1) && (b < W - 1);
      end
    end else if (t < N * P + TR) begin
      e.busy = 1'b1;
    end else begin
      e.done = 1'b1;
      e.busy = au;
    end
    return e;
  endfunction

  bit m_act = 1'b0;
  bit m_ready = 1'b0;
  int m_t = 0;
  always @(posedge clk) begin
    m_ready <= 1'b1;
    if (rst) m_act <= 1'b0;
    else if (!m_act) begin
      if (start) begin m_act <= 1'b1; m_t <= 0; end
    end else if (m_t == FRAME - 1) begin
      if (au_w) m_t <= 0;
      else m_act <= 1'b0;
    end else m_t <= m_t + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (m_ready) begin
      e = model_at(m_act, m_t, au_w);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("rd_en", rd_en, e.rd_en);
      chk("load", load, e.load);
      chk("shift", shift, e.shift);
      chk("dout", dout, e.dout);
      if (e.chk_addr) chk("addr", addr, e.addr);
    end
  end

  // Monitor: event counts and dout high/low run lengths.
  int n_done = 0, n_shift = 0, n_load = 0, n_rd1 = 0, run = 0;
  logic prev = 1'b0;
  int hq[$];
  int lq[$];
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (shift) n_shift <= n_shift + 1;
    if (load) n_load <= n_load + 1;
    if (rd_en && addr == AW'(1)) n_rd1 <= n_rd1 + 1;
    if (dout == prev) run <= run + 1;
    else begin
      if (prev) hq.push_back(run);
      else lq.push_back(run);
      run <= 1;
      prev <= dout;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      cycles(1);
      k++;
    end
    chk("done_within_budget", done, 1'b1);
    cycles(1);
  endtask

  int exp8[8] = '{4, 2, 4, 2, 2, 4, 2, 4};
  int hb, lb, d0, s0, l0, r0;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_load_shift", {load, shift}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_addr", addr, 0);
    rst = 1'b0;
    cycles(2);

    // All-ones then all-zeros pixels.
    mem[0] = 24'hFFFFFF;
    mem[1] = 24'h000000;
    hb = hq.size(); lb = lq.size();
    d0 = n_done; s0 = n_shift; l0 = n_load; r0 = n_rd1;
    pulse_start();
    wait_done(FRAME + 20);
    cycles(3);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_shift_count", n_shift - s0, 46);
    chk("t1_load_count", n_load - l0, 2);
    chk("t1_rd_addr1_count", n_rd1 - r0, 1);
    chk("t1_pulse_count", hq.size() - hb, 48);
    chk("t1_busy_after", busy, 0);
    if (hq.size() - hb >= 48) begin
      for (int i = 0; i < 48; i++) chk("t1_high_width", hq[hb+i], (i < 24) ? 4 : 2);
    end
    if (lq.size() - lb >= 26) begin
      chk("t1_low_in_pixel0", lq[lb+1], 2);
      chk("t1_gap_low", lq[lb+24], 5);
      chk("t1_low_in_pixel1", lq[lb+25], 4);
    end

    // 0xA50000 exercises alternating bit values.
    mem[0] = 24'hA50000;
    mem[1] = 24'h3C00FF;
    hb = hq.size(); s0 = n_shift; l0 = n_load;
    pulse_start();
    wait_done(FRAME + 20);
    cycles(3);
    chk("t2_shift_count", n_shift - s0, 46);
    chk("t2_load_count", n_load - l0, 2);
    if (hq.size() - hb >= 8) begin
      for (int i = 0; i < 8; i++) chk("t2_high_width", hq[hb+i], exp8[i]);
    end

    // start held high through most of the frame.
    d0 = n_done;
    start = 1'b1;
    cycles(100);
    start = 1'b0;
    wait_done(FRAME + 20);
    cycles(5);
    chk("t3_single_done", n_done - d0, 1);
    chk("t3_busy_idle", busy, 0);

    // Reset in the middle of pixel 1, then resend.
    pulse_start();
    cycles(P + 30);
    rst = 1'b1;
    cycles(1);
    chk("t4_dout_after_rst", dout, 0);
    chk("t4_busy_after_rst", busy, 0);
    chk("t4_addr_after_rst", addr, 0);
    rst = 1'b0;
    cycles(2);
    hb = hq.size();
    pulse_start();
    wait_done(FRAME + 20);
    cycles(3);
    if (hq.size() - hb >= 8) begin
      for (int i = 0; i < 8; i++) chk("t4_resend_width", hq[hb+i], exp8[i]);
    end

`ifdef LED_AUTO_REFRESH_EN
    begin
      int k;
      auto_en = 1'b1;
      pulse_start();
      wait_done(FRAME + 20);
      chk("t5_busy_after_done", busy, 1);
      k = 1;
      while (done !== 1'b1 && k < FRAME + 20) begin
        cycles(1);
        k++;
      end
      chk("t5_frame_period", k, FRAME);
      chk("t5_busy_in_done", busy, 1);
      cycles(1);
      auto_en = 1'b0;
      wait_done(FRAME + 20);
      cycles(3);
      chk("t5_busy_final", busy, 0);
    end
`endif

    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
